// File: rtl/ssb_in.sv
// Receive-side SSB mixer: multiplies the ADC stream by the LO, boxcar-accumulates
// DECIM products per window and emits one saturated I/Q pair per window, I first.
module ssb_in #(
  parameter int unsigned DECIM = 16,
  parameter int unsigned SHIFT = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] adc,
  input  logic signed [17:0] cosa,
  input  logic signed [17:0] sina,
  input  logic               enable,
  input  logic               sync,
  output logic signed [17:0] out_data,
  output logic               out_iq,
  output logic               out_valid
);

  localparam int unsigned CW   = $clog2(DECIM);
  localparam int unsigned ACCW = 34 + CW;
  localparam logic [CW-1:0]        LAST    = CW'(DECIM - 1);
  localparam logic signed [ACCW:0] SAT_MAX = (ACCW + 1)'(131071);
  localparam logic signed [ACCW:0] SAT_MIN = (ACCW + 1)'(-131072);

  typedef enum logic [1:0] {OS_IDLE, OS_I, OS_Q} os_e;

  logic signed [15:0]      a_q;
  logic signed [17:0]      c_q, s_q;
  logic                    sync0_q, sync1_q;
  logic signed [33:0]      pi_q, pq_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [ACCW-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACCW-1:0]  hold_i_q, hold_i_d, hold_q_q, hold_q_d;
  logic signed [ACCW-1:0]  pi_x, pq_x, sh_i, sh_q;
  logic signed [ACCW:0]    i_w, q_w;
  logic                    first, dump;
  os_e                     os_q, os_d;
  logic signed [17:0]      out_data_q, out_data_d;
  logic                    out_iq_q, out_iq_d, out_valid_q, out_valid_d;

  function automatic logic signed [17:0] sat18(input logic signed [ACCW:0] v);
    if (v > SAT_MAX)      return 18'sh1FFFF;
    else if (v < SAT_MIN) return 18'sh20000;
    else                  return v[17:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      c_q     <= '0;
      s_q     <= '0;
      sync0_q <= 1'b0;
      pi_q    <= '0;
      pq_q    <= '0;
      sync1_q <= 1'b0;
    end else begin
      a_q     <= enable ? adc : '0;
      c_q     <= cosa;
      s_q     <= sina;
      sync0_q <= sync;
      pi_q    <= 34'(a_q) * 34'(c_q);
      pq_q    <= 34'(a_q) * 34'(s_q);
      sync1_q <= sync0_q;
    end
  end

  // A sync on the last slot wins: the sample restarts a window, so no dump.
  always_comb begin
    pi_x     = ACCW'(pi_q);
    pq_x     = ACCW'(pq_q);
    first    = sync1_q || (cnt_q == '0);
    dump     = (cnt_q == LAST) && !sync1_q;
    acc_i_d  = first ? pi_x : acc_i_q + pi_x;
    acc_q_d  = first ? pq_x : acc_q_q + pq_x;
    hold_i_d = dump ? acc_i_d : hold_i_q;
    hold_q_d = dump ? acc_q_d : hold_q_q;
    if (sync1_q)            cnt_d = CW'(1);
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    sh_i        = hold_i_q >>> SHIFT;
    sh_q        = hold_q_q >>> SHIFT;
    i_w         = (ACCW + 1)'(sh_i);
    q_w         = -((ACCW + 1)'(sh_q));
    os_d        = dump ? OS_I : ((os_q == OS_I) ? OS_Q : OS_IDLE);
    out_data_d  = out_data_q;
    out_iq_d    = out_iq_q;
    out_valid_d = 1'b0;
    case (os_q)
      OS_I: begin
        out_data_d  = sat18(i_w);
        out_iq_d    = 1'b0;
        out_valid_d = 1'b1;
      end
      OS_Q: begin
        out_data_d  = sat18(q_w);
        out_iq_d    = 1'b1;
        out_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      os_q        <= OS_IDLE;
      out_data_q  <= '0;
      out_iq_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      hold_i_q    <= hold_i_d;
      hold_q_q    <= hold_q_d;
      os_q        <= os_d;
      out_data_q  <= out_data_d;
      out_iq_q    <= out_iq_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_iq    = out_iq_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ssb_in.sv
// Bench for ssb_in: directed and random stimulus compared every cycle against a
// window-level reference model, plus directed constant checks.
module tb_ssb_in;

  localparam int DECIM = 16;
  localparam int SHIFT = 19;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] adc;
  logic signed [17:0] cosa, sina;
  logic               enable, sync;
  logic signed [17:0] out_data;
  logic               out_iq, out_valid;

  ssb_in #(.DECIM(DECIM), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .adc(adc), .cosa(cosa), .sina(sina),
    .enable(enable), .sync(sync),
    .out_data(out_data), .out_iq(out_iq), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct { longint a; longint c; longint s; bit sy; } smp_t;
  typedef struct { longint e; longint d; bit iq; } ev_t;

  int     tests = 0, fails = 0;
  longint cur_edge = 0;
  smp_t   dl [2];
  longint wi [$], wq [$];
  ev_t    sched [$];
  longint m_data = 0;
  bit     m_iq = 0, m_valid = 0;
  longint last_i = 0, last_q = 0, last_i_edge = 0, prev_i_edge = 0, e_last = 0;
  int     npairs = 0, np0 = 0;

  function automatic longint sat(input longint v);
    if (v > 131071)  return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cur_edge);
    end
  endtask

  // Reference: the sample entering at edge t reaches the window at edge t+2; a full
  // window produces I on the next edge and Q on the one after.
  task automatic model_edge();
    smp_t   cur;
    longint si, sq;
    cur_edge++;
    if (rst) begin
      dl[0] = '{0, 0, 0, 0};
      dl[1] = '{0, 0, 0, 0};
      wi.delete(); wq.delete(); sched.delete();
      m_valid = 0; m_iq = 0; m_data = 0;
      return;
    end
    m_valid = 0;
    if (sched.size() > 0 && sched[0].e == cur_edge) begin
      m_valid = 1; m_data = sched[0].d; m_iq = sched[0].iq;
      void'(sched.pop_front());
    end
    cur   = dl[0];
    dl[0] = dl[1];
    dl[1] = '{enable ? longint'(adc) : 0, longint'(cosa), longint'(sina), sync};
    if (cur.sy) begin wi.delete(); wq.delete(); end
    wi.push_back(cur.a * cur.c);
    wq.push_back(cur.a * cur.s);
    if (wi.size() == DECIM) begin
      si = 0; sq = 0;
      foreach (wi[k]) begin si += wi[k]; sq += wq[k]; end
      sched.push_back('{e: cur_edge + 1, d: sat(si >>> SHIFT), iq: 1'b0});
      sched.push_back('{e: cur_edge + 2, d: sat(-(sq >>> SHIFT)), iq: 1'b1});
      wi.delete(); wq.delete();
    end
  endtask

  task automatic step(input logic signed [15:0] a, input logic signed [17:0] c,
                      input logic signed [17:0] s, input logic en, input logic sy,
                      input logic r);
    adc = a; cosa = c; sina = s; enable = en; sync = sy; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", out_valid, m_valid);
    chk("iq", out_iq, m_iq);
    chk("data", out_data, m_data);
    if (out_valid && !out_iq) begin
      prev_i_edge = last_i_edge; last_i_edge = cur_edge; last_i = out_data;
    end
    if (out_valid && out_iq) begin
      last_q = out_data; npairs++;
    end
  endtask

  task automatic dc(input logic sy);
    step(16'sd16384, 18'sd131071, 18'sd0, 1'b1, sy, 1'b0);
  endtask

  initial begin
    dl[0] = '{0, 0, 0, 0};
    dl[1] = '{0, 0, 0, 0};
    adc = '0; cosa = '0; sina = '0; enable = 1'b0; sync = 1'b0; rst = 1'b1;

    // reset
    for (int i = 0; i < 3; i++) step(16'sd0, 18'sd0, 18'sd0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_iq", out_iq, 0);

    // DC I window with sync on its first sample; latency of the pair
    for (int i = 0; i < DECIM; i++) dc(i == 0);
    e_last = cur_edge;
    dc(1'b0); dc(1'b0); dc(1'b0);
    chk("lat_i_edge", last_i_edge, e_last + 3);
    chk("lat_i_val", out_valid, 1);
    chk("lat_i_iq", out_iq, 0);
    chk("dc_i", out_data, 65535);
    dc(1'b0);
    chk("lat_q_iq", out_iq, 1);
    chk("dc_q", out_data, 0);
    dc(1'b0);
    chk("lat_after", out_valid, 0);
    for (int i = 0; i < 40; i++) dc(1'b0);
    chk("spacing", last_i_edge - prev_i_edge, DECIM);
    chk("dc_i_repeat", last_i, 65535);

    // saturation
    for (int i = 0; i < DECIM + 4; i++)
      step(-16'sd32768, -18'sd131072, -18'sd131072, 1'b1, i == 0, 1'b0);
    chk("sat_i", last_i, 131071);
    chk("sat_q", last_q, -131072);

    // mid-window sync discards the partial window
    np0 = npairs;
    for (int i = 0; i < 5; i++) dc(i == 0);
    for (int i = 0; i < DECIM; i++) dc(i == 0);
    dc(1'b0); dc(1'b0);
    chk("midsync_nodump", npairs, np0);
    dc(1'b0); dc(1'b0);
    chk("midsync_pair", npairs, np0 + 1);
    chk("midsync_i", last_i, 65535);

    // enable low for one window, then restored
    for (int i = 0; i < DECIM; i++) step(16'sd16384, 18'sd131071, 18'sd0, 1'b0, i == 0, 1'b0);
    for (int i = 0; i < 4; i++) dc(1'b0);
    chk("en0_i", last_i, 0);
    chk("en0_q", last_q, 0);
    for (int i = 0; i < DECIM; i++) dc(1'b0);
    chk("en1_i", last_i, 65535);

    // reset mid-window
    for (int i = 0; i < 7; i++) dc(i == 0);
    step(16'sd16384, 18'sd131071, 18'sd0, 1'b1, 1'b0, 1'b1);
    chk("rstw_valid", out_valid, 0);
    chk("rstw_data", out_data, 0);
    // reset mid-pair
    for (int k = 0; k < 3 * DECIM && !(out_valid && !out_iq); k++) dc(1'b0);
    chk("midpair_seen", out_valid && !out_iq, 1);
    step(16'sd16384, 18'sd131071, 18'sd0, 1'b1, 1'b0, 1'b1);
    chk("rstp_valid", out_valid, 0);
    chk("rstp_data", out_data, 0);
    np0 = npairs;
    for (int i = 0; i < DECIM; i++) dc(1'b0);
    chk("rst_nopair_yet", npairs, np0);
    for (int i = 0; i < DECIM + 4; i++) dc(1'b0);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(16'($urandom), 18'($urandom), 18'($urandom),
           $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 249) == 0);
    for (int i = 0; i < 6; i++) step(16'sd0, 18'sd0, 18'sd0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
